n_alloc: RTL and testbench

Multi-channel, round-robin slot allocator over a W-entry occupancy bitmap. Each cycle it offers up to K free slot indices, found by a circular downward search for zero bits starting just below a registered pointer. It also accepts one slot release per cycle. It is used wherever the design hands out tags, buffer entries or IDs from a fixed pool, and it builds the circular find-zero search into a stateful, handshaked block.

---
 rtl/n_pkg.sv | 9 +
 rtl/n_alloc_srch.sv | 40 ++++
 rtl/n_alloc.sv | 80 ++++++++
 tb/tb_n_alloc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n_pkg.sv
// n_pkg: slot-id typedef macro, popcount helper and illegal-free check shared by the n_alloc slice.
`define N_SLOT_ID_T(w) typedef logic [$clog2(w)-1:0] slot_id_t;
`define N_ASSERT_FREE(clk, rst_n, vld, ok) assert property (@(posedge clk) disable iff (!rst_n) (vld) |-> (ok)) else $warning("n_alloc: release of unallocated or out-of-range slot ignored");
package n_pkg;
    function automatic logic [7:0] popcount(input logic [63:0] v);
        popcount = '0;
        for (int i = 0; i < 64; i++) popcount += 8'(v[i]);
    endfunction
endpackage

// File: rtl/n_alloc_srch.sv
// n_alloc_srch: circular downward search for the first zero of mask, starting just below ptr.
module n_alloc_srch #(
    parameter int W = 32,
    parameter bit INFER = 1'b0,
    localparam int IW = $clog2(W)
) (
    input  logic [W-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  oh,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [W-1:0] free;
    assign free = ~mask;
    assign any = |free;
    assign oh = any ? W'(1) << idx : '0;
    if (INFER) begin : g_rot
        logic [W-1:0] rot;
        logic [IW-1:0] j;
        logic [IW:0] s;
        // after rotating right by ptr, slot ptr-1 sits at the top, so the MSB is the first hit
        always_comb begin
            rot = W'({free, free} >> ptr);
            j = '0;
            for (int i = 0; i < W; i++) if (rot[i]) j = IW'(i);
            s = {1'b0, j} + {1'b0, ptr};
            idx = s >= (IW+1)'(W) ? IW'(s - (IW+1)'(W)) : IW'(s);
        end
    end else begin : g_pos
        logic [W-1:0] lo;
        logic [W-1:0] sel;
        // highest zero below ptr wins; if none, the search has wrapped to the highest zero overall
        always_comb begin
            for (int i = 0; i < W; i++) lo[i] = free[i] & (IW'(i) < ptr);
            sel = |lo ? lo : free;
            idx = '0;
            for (int i = 0; i < W; i++) if (sel[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/n_alloc.sv
// n_alloc: K-channel round-robin slot allocator over a W-entry occupancy bitmap.
module n_alloc
    import n_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 2,
    parameter bit INFER = 1'b0
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [K-1:0]           alloc_vld_i,
    output logic [K-1:0]           alloc_rdy_o,
    output logic [K*$clog2(W)-1:0] alloc_id_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_id_i,
    output logic [W-1:0]           occ_o,
    output logic [$clog2(W+1)-1:0] cnt_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);
    localparam int N2 = 1 << IW;
    `N_SLOT_ID_T(W)
    logic [W-1:0] occ, set, occ_n;
    slot_id_t ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0] m [K];
    logic [W-1:0] oh [K];
    slot_id_t id [K];
    logic [K-1:0] any, g;
    logic [N2-1:0] occ_ext;
    logic legal;
    // each channel searches the bitmap with all lower channels' candidates already marked taken
    for (genvar k = 0; k < K; k++) begin : g_ch
        if (k == 0) begin : g_head
            assign m[k] = occ;
        end else begin : g_link
            assign m[k] = m[k-1] | oh[k-1];
        end
        n_alloc_srch #(.W(W), .INFER(INFER)) u_srch (
            .mask(m[k]),
            .ptr (ptr),
            .oh  (oh[k]),
            .idx (id[k]),
            .any (any[k])
        );
        assign alloc_rdy_o[k] = any[k] & arst_n;
        assign alloc_id_o[k*IW +: IW] = id[k];
    end
    always_comb begin
        g = alloc_vld_i & alloc_rdy_o;
        set = '0;
        ptr_n = ptr;
        for (int i = 0; i < K; i++) begin
            set = g[i] ? set | oh[i] : set;
            ptr_n = g[i] ? id[i] : ptr_n;
        end
        occ_ext = N2'(occ);
        legal = free_vld_i & occ_ext[free_id_i];
        occ_n = (occ | set) & ~(legal ? W'(N2'(1) << free_id_i) : '0);
        cnt_n = cnt + CW'(popcount(64'(g))) - CW'(legal);
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            occ <= occ_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
        end
    end
    `N_ASSERT_FREE(clk, arst_n, free_vld_i, legal)
    assign occ_o = occ;
    assign cnt_o = cnt;
    assign full_o = cnt == CW'(W);
    assign empty_o = cnt == '0;
endmodule

// File: tb/tb_n_alloc.sv
// tb_n_alloc: directed and randomized checks of n_alloc (W=8, K=2, both INFER settings) against a search-order model.
module tb_n_alloc;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic [1:0] vld = '0;
    logic fv = 1'b0;
    logic [2:0] fid = '0;
    logic [1:0] rdy [2];
    logic [5:0] ids [2];
    logic [7:0] occ [2];
    logic [3:0] cnt [2];
    logic full [2];
    logic empty [2];
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m_occ = '0;
    logic [2:0] m_ptr = '0;
    int mn;
    int mc [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        n_alloc #(.W(8), .K(2), .INFER(d == 1)) u_dut (
            .clk        (clk),
            .arst_n     (arst_n),
            .alloc_vld_i(vld),
            .alloc_rdy_o(rdy[d]),
            .alloc_id_o (ids[d]),
            .free_vld_i (fv),
            .free_id_i  (fid),
            .occ_o      (occ[d]),
            .cnt_o      (cnt[d]),
            .full_o     (full[d]),
            .empty_o    (empty[d])
        );
    end

    // walk ptr-1, ptr-2, ... around the ring and take the first two free slots
    task automatic find_cands();
        mn = 0;
        for (int s = 1; s <= 8; s++) begin
            int i;
            i = (int'(m_ptr) + 8 - s) % 8;
            if (!m_occ[i] && mn < 2) begin
                mc[mn] = i;
                mn++;
            end
        end
    endtask

    task automatic model_step(input logic [1:0] v, input logic f, input logic [2:0] id);
        logic [7:0] nxt;
        find_cands();
        nxt = m_occ;
        for (int k = 0; k < 2; k++) begin
            if (v[k] && k < mn) begin
                nxt[mc[k]] = 1'b1;
                m_ptr = 3'(mc[k]);
            end
        end
        if (f && m_occ[id]) nxt[id] = 1'b0;
        m_occ = nxt;
    endtask

    task automatic cyc(input logic [1:0] v, input logic f, input logic [2:0] id);
        vld = v;
        fv = f;
        fid = id;
        model_step(v, f, id);
        @(posedge clk);
        #1;
        vld = '0;
        fv = 1'b0;
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        m_occ = '0;
        m_ptr = '0;
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        vld = 2'b11;
        #12;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rdy[d] !== 2'b00 || occ[d] !== 8'h00 || cnt[d] !== 4'd0 || empty[d] !== 1'b1 || full[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold dut%0d: rdy=%b occ=%h cnt=%0d empty=%b full=%b, want 00/00/0/1/0", d, rdy[d], occ[d], cnt[d], empty[d], full[d]);
            end
        end
        arst_n = 1'b1;
        vld = '0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rdy[d] !== 2'b11 || ids[d] !== {3'd6, 3'd7}) begin
                n_bad++;
                $display("FAIL reset_offer dut%0d: rdy=%b ids=%h, want rdy=11 ids=%h", d, rdy[d], ids[d], {3'd6, 3'd7});
            end
        end
    endtask

    task automatic test_fill();
        cyc(2'b11, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'hC0 || cnt[d] !== 4'd2 || ids[d] !== {3'd4, 3'd5}) begin
                n_bad++;
                $display("FAIL first_dual dut%0d: occ=%h cnt=%0d ids=%h, want occ=c0 cnt=2 ids=%h", d, occ[d], cnt[d], ids[d], {3'd4, 3'd5});
            end
        end
        repeat (3) cyc(2'b11, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'hFF || cnt[d] !== 4'd8 || full[d] !== 1'b1 || rdy[d] !== 2'b00) begin
                n_bad++;
                $display("FAIL fill dut%0d: occ=%h cnt=%0d full=%b rdy=%b, want ff/8/1/00", d, occ[d], cnt[d], full[d], rdy[d]);
            end
        end
        repeat (2) cyc(2'b11, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'hFF || cnt[d] !== 4'd8) begin
                n_bad++;
                $display("FAIL full_hold dut%0d: occ=%h cnt=%0d, want ff/8", d, occ[d], cnt[d]);
            end
        end
    endtask

    task automatic test_free_from_full();
        cyc(2'b00, 1'b1, 3'd3);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rdy[d] !== 2'b01 || ids[d][2:0] !== 3'd3 || full[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL free_full dut%0d: rdy=%b id0=%0d full=%b, want 01/3/0", d, rdy[d], ids[d][2:0], full[d]);
            end
        end
        cyc(2'b01, 1'b0, 3'd0);
        cyc(2'b00, 1'b1, 3'd5);
        cyc(2'b00, 1'b1, 3'd1);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rdy[d] !== 2'b11 || ids[d] !== {3'd5, 3'd1}) begin
                n_bad++;
                $display("FAIL ptr_after_refill dut%0d: rdy=%b ids=%h, want 11 ids=%h", d, rdy[d], ids[d], {3'd5, 3'd1});
            end
        end
        cyc(2'b11, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (full[d] !== 1'b1 || occ[d] !== 8'hFF) begin
                n_bad++;
                $display("FAIL refill dut%0d: full=%b occ=%h, want 1/ff", d, full[d], occ[d]);
            end
        end
    endtask

    task automatic test_wrap();
        cyc(2'b00, 1'b1, 3'd1);
        cyc(2'b01, 1'b0, 3'd0);
        cyc(2'b00, 1'b1, 3'd7);
        cyc(2'b00, 1'b1, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'h7E || rdy[d] !== 2'b11 || ids[d] !== {3'd7, 3'd0}) begin
                n_bad++;
                $display("FAIL wrap_offer dut%0d: occ=%h rdy=%b ids=%h, want 7e/11/%h", d, occ[d], rdy[d], ids[d], {3'd7, 3'd0});
            end
        end
        cyc(2'b11, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'hFF) begin
                n_bad++;
                $display("FAIL wrap_grant dut%0d: occ=%h, want ff", d, occ[d]);
            end
        end
    endtask

    task automatic test_skip_channel();
        apply_reset();
        cyc(2'b10, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'h40 || ids[d] !== {3'd4, 3'd5}) begin
                n_bad++;
                $display("FAIL skip_ch0 dut%0d: occ=%h ids=%h, want 40 ids=%h", d, occ[d], ids[d], {3'd4, 3'd5});
            end
        end
        repeat (6) cyc(2'b01, 1'b0, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rdy[d] !== 2'b01 || ids[d][2:0] !== 3'd7 || occ[d] !== 8'h7F) begin
                n_bad++;
                $display("FAIL skipped_slot_last dut%0d: rdy=%b id0=%0d occ=%h, want 01/7/7f", d, rdy[d], ids[d][2:0], occ[d]);
            end
        end
    endtask

    task automatic test_simul_and_illegal();
        apply_reset();
        cyc(2'b11, 1'b0, 3'd0);
        cyc(2'b11, 1'b0, 3'd0);
        cyc(2'b11, 1'b1, 3'd7);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (cnt[d] !== 4'd5 || occ[d] !== 8'h7C) begin
                n_bad++;
                $display("FAIL grant_and_free dut%0d: cnt=%0d occ=%h, want 5/7c", d, cnt[d], occ[d]);
            end
        end
        cyc(2'b00, 1'b1, 3'd0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (cnt[d] !== 4'd5 || occ[d] !== 8'h7C) begin
                n_bad++;
                $display("FAIL illegal_free dut%0d: cnt=%0d occ=%h, want 5/7c", d, cnt[d], occ[d]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            logic [1:0] v;
            logic f;
            logic [2:0] id;
            v = 2'($urandom);
            id = 3'($urandom);
            f = ($urandom % 3) != 0;
            if (!m_occ[id] && ($urandom % 8) != 0) f = 1'b0;
            cyc(v, f, id);
            find_cands();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (rdy[d] !== {mn > 1, mn > 0}) begin
                    n_bad++;
                    $display("FAIL rnd_rdy dut%0d n=%0d: rdy=%b, want %b", d, n, rdy[d], {mn > 1, mn > 0});
                end
                if (mn > 0) begin
                    n_cmp++;
                    if (ids[d][2:0] !== 3'(mc[0])) begin
                        n_bad++;
                        $display("FAIL rnd_id0 dut%0d n=%0d: id0=%0d, want %0d", d, n, ids[d][2:0], mc[0]);
                    end
                end
                if (mn > 1) begin
                    n_cmp++;
                    if (ids[d][5:3] !== 3'(mc[1])) begin
                        n_bad++;
                        $display("FAIL rnd_id1 dut%0d n=%0d: id1=%0d, want %0d", d, n, ids[d][5:3], mc[1]);
                    end
                end
                n_cmp++;
                if (occ[d] !== m_occ || cnt[d] !== 4'($countones(m_occ)) || full[d] !== (m_occ == 8'hFF) || empty[d] !== (m_occ == 8'h00)) begin
                    n_bad++;
                    $display("FAIL rnd_state dut%0d n=%0d: occ=%h cnt=%0d full=%b empty=%b, want occ=%h cnt=%0d", d, n, occ[d], cnt[d], full[d], empty[d], m_occ, $countones(m_occ));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(2'b11, 1'b0, 3'd0);
        vld = 2'b11;
        arst_n = 1'b0;
        m_occ = '0;
        m_ptr = '0;
        #2;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'h00 || empty[d] !== 1'b1 || cnt[d] !== 4'd0 || rdy[d] !== 2'b00) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: occ=%h empty=%b cnt=%0d rdy=%b, want 00/1/0/00", d, occ[d], empty[d], cnt[d], rdy[d]);
            end
        end
        #2;
        arst_n = 1'b1;
        vld = '0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (occ[d] !== 8'h00 || rdy[d] !== 2'b11 || ids[d] !== {3'd6, 3'd7}) begin
                n_bad++;
                $display("FAIL after_async_reset dut%0d: occ=%h rdy=%b ids=%h, want 00/11/%h", d, occ[d], rdy[d], ids[d], {3'd6, 3'd7});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_free_from_full();
        test_wrap();
        test_skip_channel();
        test_simul_and_illegal();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
